// File: rtl/pc_fetch_if.sv
// Fetch-side bus: next-PC loop, instruction-memory req/ack and decode valid/ready.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface pc_fetch_if;
    logic [31:0] nextPc;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instr;
    logic        instrReady;

    modport master (
        input  nextPc, flush, imemAck, imemData, instrReady,
        output pc, pcPlus4, imemReq, imemAddr, instrValid, instr
    );

    modport slave (
        output nextPc, flush, imemAck, imemData, instrReady,
        input  pc, pcPlus4, imemReq, imemAddr, instrValid, instr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer closing the next-PC loop.
//   state | meaning
//   IDLE  | no request outstanding; issue a fetch of pc on the next edge
//   REQ   | fetch of imemAddr outstanding, data will be delivered
//   HOLD  | instr valid, waiting for decode to accept it
//   DRAIN | redirected while a fetch was outstanding; wait for ack, discard data
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchStateT;

    fetchStateT  state, stateNext;
    logic [31:0] pcQ, pcNext;
    logic [31:0] addrQ, addrNext;
    logic        reqQ, reqNext;
    logic        validQ, validNext;
    logic [31:0] instrQ, instrNext;
    logic [31:0] target;

    assign target = bus.nextPc & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcQ    <= RESET_PC & ALIGN_MASK;
            addrQ  <= RESET_PC & ALIGN_MASK;
            reqQ   <= 1'b0;
            validQ <= 1'b0;
            instrQ <= 32'h0;
        end else begin
            state  <= stateNext;
            pcQ    <= pcNext;
            addrQ  <= addrNext;
            reqQ   <= reqNext;
            validQ <= validNext;
            instrQ <= instrNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pcQ;
        addrNext  = addrQ;
        reqNext   = reqQ;
        validNext = validQ;
        instrNext = instrQ;
        unique case (state)
            IDLE: begin
                stateNext = REQ;
                reqNext   = 1'b1;
                if (bus.flush) begin
                    pcNext   = target;
                    addrNext = target;
                end else begin
                    addrNext = pcQ;
                end
            end
            REQ: begin
                if (bus.imemAck && !bus.flush) begin
                    instrNext = bus.imemData;
                    validNext = 1'b1;
                    reqNext   = 1'b0;
                    stateNext = HOLD;
                end else if (bus.imemAck) begin
                    pcNext    = target;
                    reqNext   = 1'b0;
                    stateNext = IDLE;
                end else if (bus.flush) begin
                    // request must stay up with its original address until acked
                    pcNext    = target;
                    stateNext = DRAIN;
                end
            end
            HOLD: begin
                // a flush reloads exactly like a handoff; decode sees it as not taken
                if (bus.instrReady || bus.flush) begin
                    validNext = 1'b0;
                    pcNext    = target;
                    addrNext  = target;
                    reqNext   = 1'b1;
                    stateNext = REQ;
                end
            end
            DRAIN: begin
                if (bus.flush) pcNext = target;
                if (bus.imemAck) begin
                    reqNext   = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.pc         = pcQ;
    assign bus.pcPlus4    = pcQ + 32'd4;
    assign bus.imemReq    = reqQ;
    assign bus.imemAddr   = addrQ;
    assign bus.instrValid = validQ;
    assign bus.instr      = instrQ;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed test-plan sequences then randomized traffic,
// checked every cycle against a flag-based transaction model of the fetch loop.
module tb_pc_fetch_unit;
    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nFail   = 0;
    bit   cmpEn   = 1'b1;
    bit   autoAck = 1'b1;
    bit   tiePc   = 1'b1;

    pc_fetch_if bus();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1111_0000 + addr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is outstanding (mReq), possibly already redirected away (mStale),
    // or an instruction is waiting for decode (mValid); none of these means idle.
    logic [31:0] mPc, mAddr, mInstr, tgt;
    bit          mReq, mValid, mStale;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPc = 32'h0; mAddr = 32'h0; mInstr = 32'h0;
            mReq = 1'b0; mValid = 1'b0; mStale = 1'b0;
        end else begin
            tgt = {bus.nextPc[31:2], 2'b00};
            if (mValid) begin
                if (bus.flush || bus.instrReady) begin
                    mValid = 1'b0; mPc = tgt; mAddr = tgt; mReq = 1'b1;
                end
            end else if (!mReq) begin
                if (bus.flush) mPc = tgt;
                mAddr = mPc;
                mReq  = 1'b1;
            end else if (mStale) begin
                if (bus.flush) mPc = tgt;
                if (bus.imemAck) begin
                    mReq = 1'b0; mStale = 1'b0;
                end
            end else if (bus.imemAck) begin
                mReq = 1'b0;
                if (bus.flush) mPc = tgt;
                else begin
                    mValid = 1'b1; mInstr = bus.imemData;
                end
            end else if (bus.flush) begin
                mPc = tgt; mStale = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("pc", bus.pc, mPc);
            check("pcPlus4", bus.pcPlus4, mPc + 32'd4);
            check("imemReq", {31'b0, bus.imemReq}, {31'b0, mReq});
            check("imemAddr", bus.imemAddr, mAddr);
            check("instrValid", {31'b0, bus.instrValid}, {31'b0, mValid});
            check("instr", bus.instr, mInstr);
            if (mValid) check("instrOfPc", bus.instr, memWord(bus.pc));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (autoAck) begin
            bus.imemAck  = bus.imemReq;
            bus.imemData = bus.imemReq ? memWord(bus.imemAddr) : $urandom;
        end
        if (tiePc) bus.nextPc = bus.pcPlus4;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.nextPc = 32'h0; bus.flush = 1'b0; bus.imemAck = 1'b0;
        bus.imemData = 32'h0; bus.instrReady = 1'b1;
        tick();
        check("rstReq", {31'b0, bus.imemReq}, 32'd0);
        check("rstPc", bus.pc, 32'h0);
        check("rstValid", {31'b0, bus.instrValid}, 32'd0);
        tick();
        rst_n = 1'b1;

        // reset release and sequential stream
        tick();
        check("firstReq", {31'b0, bus.imemReq}, 32'd1);
        check("firstAddr", bus.imemAddr, 32'h0);
        check("firstPcPlus4", bus.pcPlus4, 32'h4);
        tick();
        check("seqInstr0", bus.instr, 32'h1111_0000);
        check("seqPc0", bus.pc, 32'h0);
        tick();
        tick();
        check("seqInstr1", bus.instr, 32'h1111_0004);
        check("seqPc1", bus.pc, 32'h4);
        tick();
        tick();
        check("seqInstr2", bus.instr, 32'h1111_0008);
        check("seqPc2", bus.pc, 32'h8);

        // decode backpressure
        bus.instrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bpValid", {31'b0, bus.instrValid}, 32'd1);
            check("bpInstr", bus.instr, 32'h1111_0008);
            check("bpReq", {31'b0, bus.imemReq}, 32'd0);
        end

        // flush in HOLD together with instrReady
        tiePc = 1'b0;
        bus.nextPc = 32'h0000_0100; bus.flush = 1'b1; bus.instrReady = 1'b1;
        tick();
        check("flValid", {31'b0, bus.instrValid}, 32'd0);
        check("flPc", bus.pc, 32'h100);
        check("flReq", {31'b0, bus.imemReq}, 32'd1);
        check("flAddr", bus.imemAddr, 32'h100);
        bus.flush = 1'b0; tiePc = 1'b1; bus.nextPc = bus.pcPlus4;
        tick();
        tiePc = 1'b0; autoAck = 1'b0; bus.imemAck = 1'b0; bus.nextPc = 32'h20;

        // flush with a request outstanding
        tick();
        check("outAddr", bus.imemAddr, 32'h20);
        bus.flush = 1'b1; bus.nextPc = 32'h200;
        tick();
        bus.flush = 1'b0;
        check("drPc", bus.pc, 32'h200);
        for (int i = 0; i < 2; i++) begin
            check("drAddr", bus.imemAddr, 32'h20);
            check("drReq", {31'b0, bus.imemReq}, 32'd1);
            tick();
        end
        bus.imemAck = 1'b1; bus.imemData = 32'hDEAD_BEEF;
        tick();
        bus.imemAck = 1'b0;
        check("drIdleValid", {31'b0, bus.instrValid}, 32'd0);
        tick();
        check("drNewAddr", bus.imemAddr, 32'h200);
        check("drNewReq", {31'b0, bus.imemReq}, 32'd1);
        bus.imemAck = 1'b1; bus.imemData = memWord(bus.imemAddr);
        tick();
        bus.imemAck = 1'b0;
        check("drNewInstr", bus.instr, 32'h1111_0200);

        // wrap and alignment
        bus.nextPc = 32'hFFFF_FFFF;
        tick();
        check("wrPc", bus.pc, 32'hFFFF_FFFC);
        check("wrPcPlus4", bus.pcPlus4, 32'h0);
        bus.imemAck = 1'b1; bus.imemData = memWord(bus.imemAddr); bus.nextPc = bus.pcPlus4;
        tick();
        bus.imemAck = 1'b0;
        check("wrInstr", bus.instr, 32'h1110_FFFC);
        tick();
        check("wrNextAddr", bus.imemAddr, 32'h0);

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            bus.flush      = ($urandom_range(0, 99) < 8);
            bus.instrReady = $urandom_range(0, 1);
            bus.nextPc     = ($urandom_range(0, 3) == 0) ? $urandom : bus.pcPlus4;
            bus.imemAck    = bus.imemReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus.imemData   = bus.imemAck ? memWord(bus.imemAddr) : $urandom;
            if (i % 700 == 350) begin
                #2 rst_n = 1'b0;
                #1;
                check("asyncReq", {31'b0, bus.imemReq}, 32'd0);
                check("asyncPc", bus.pc, 32'h0);
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer that sits directly downstream of the 32-bit next-PC 2:1 select.
- Captures the selected next PC and drives instruction-memory requests with a req/ack handshake.
- Hands fetched instructions to decode with a valid/ready handshake.
- Supplies pcPlus4 back to the select's sequential-path input, closing the PC loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- nextPc  input  32  selected next PC from the next-PC select; bits [1:0] ignored.
- flush  input  1  redirect request; discards any in-flight or held instruction and loads nextPc.
- pc  output  32  address of the instruction being fetched or held.
- pcPlus4  output  32  pc + 4, combinational, modulo 2^32.
- imemReq  output  1  instruction-memory request (registered).
- imemAddr  output  32  request address (registered); stable while imemReq=1.
- imemAck  input  1  memory completion; imemData is valid in the same cycle.
- imemData  input  32  instruction word from memory.
- instrValid  output  1  instr holds a valid instruction for decode.
- instr  output  32  fetched instruction (registered).
- instrReady  input  1  decode accepts the instruction.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - pc=RESET_PC, imemAddr=RESET_PC, imemReq=0, instrValid=0, instr=0, state=IDLE.
- pc[1:0] and imemAddr[1:0] are always 0; pc loads from {nextPc[31:2],2'b00}.
- States:
  - IDLE: next edge goes to REQ with imemReq<=1 and imemAddr<=pc. flush in IDLE: pc<=nextPc, imemAddr<=nextPc, go to REQ.
  - REQ: imemReq=1; imemAddr held constant.
    - imemAck & !flush: instr<=imemData, instrValid<=1, imemReq<=0, go to HOLD.
    - imemAck & flush: drop data, pc<=nextPc, imemReq<=0, go to IDLE.
    - flush & !imemAck: pc<=nextPc; imemReq and imemAddr stay unchanged; go to DRAIN.
  - HOLD: instrValid=1; instr and pc held stable.
    - instrReady & !flush: instrValid<=0, pc<=nextPc, imemAddr<=nextPc, imemReq<=1, go to REQ.
    - flush (with or without instrReady): identical register updates to the line above, but the held instruction counts as NOT transferred. Decode must qualify acceptance with !flush.
  - DRAIN: imemReq=1 with the stale imemAddr until imemAck.
    - On imemAck: discard the data, imemReq<=0, go to IDLE.
    - A further flush in DRAIN reloads pc<=nextPc; the latest redirect wins.
- Latency and throughput:
  - Request issue is 1 cycle after entry to IDLE.
  - Ack to instrValid is 1 cycle.
  - Handoff to the next imemReq is 1 cycle.
  - Minimum 2 cycles per instruction when ack is zero-wait.
- Memory protocol: imemReq never drops before imemAck. Acks received while imemReq=0 are ignored.
- instrValid never drops without instrReady or flush.
- pcPlus4 wraps: pc=32'hFFFF_FFFC gives pcPlus4=32'h0000_0000.
- Reset mid-transaction forces IDLE immediately. Any ack arriving afterwards with imemReq=0 is ignored.

Test Plan:
- Reset and first fetch:
  - Stimulus: release rst_n with RESET_PC=0.
  - Required: imemReq=1 and imemAddr=0 one cycle later; pcPlus4=4 throughout.
- Sequential stream:
  - Stimulus: nextPc tied to pcPlus4; zero-wait ack returns 32'h1111_0000+addr; instrReady=1.
  - Required: instr values 0x11110000, 0x11110004, 0x11110008 at a 2-cycle cadence; pc 0, 4, 8.
- Decode backpressure:
  - Stimulus: hold instrReady=0 for 5 cycles in HOLD.
  - Required: instrValid stays 1; instr and pc stable; imemReq stays 0.
- Flush in HOLD:
  - Stimulus: pc=8, nextPc=32'h0000_0100, flush=1 together with instrReady=1.
  - Required: next cycle instrValid=0, pc=0x100, imemReq=1, imemAddr=0x100.
- Flush while a request is outstanding:
  - Stimulus: REQ at address 0x20, ack delayed 3 cycles, flush with nextPc=0x200.
  - Required: imemAddr stays 0x20 until ack; the acked data never appears on instr; the next request goes to 0x200; pc=0x200.
- Wrap and alignment:
  - Stimulus: nextPc=32'hFFFF_FFFF at handoff.
  - Required: pc=0xFFFF_FFFC, pcPlus4=0; the following sequential fetch goes to address 0.
